// File: rtl/stream_demux_if.sv
// stream_demux_if: ingress stream plus per-channel egress bundle for stream_demux_1ton.
// The master modport is the demultiplexer's view. The slave modport is the
// surrounding environment, which drives the ingress beats and the sink readies.
interface stream_demux_if #(
   parameter int DATA_W = 8,
   parameter int NUM_CH = 16,
   parameter int SEL_W  = 4
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic [SEL_W-1:0]  s_sel;
   logic              s_last;
   logic [NUM_CH-1:0] m_valid;
   logic [NUM_CH-1:0] m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;

   modport master (
      input  s_valid, s_data, s_sel, s_last, m_ready,
      output s_ready, m_valid, m_data, m_last
   );

   modport slave (
      output s_valid, s_data, s_sel, s_last, m_ready,
      input  s_ready, m_valid, m_data, m_last
   );
endinterface

// File: rtl/stream_demux_1ton.sv
// stream_demux_1ton: registered 1-to-NUM_CH packet demultiplexer.
// The first beat of a packet selects the channel, and that channel is locked
// until the last beat. Packets whose select is out of range are swallowed and
// flagged once on err_sel.
// Optional feature macro: STREAM_DEMUX_PKT_CNT_EN adds a saturating count of
// delivered packets on pkt_count.
module stream_demux_1ton #(
   parameter int DATA_W = 8,
   parameter int NUM_CH = 16,
   parameter int SEL_W  = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   stream_demux_if.master bus,
   output logic           err_sel
`ifdef STREAM_DEMUX_PKT_CNT_EN
   ,
   output logic [15:0]    pkt_count
`endif
);

   generate
      if (SEL_W != $clog2(NUM_CH)) begin : g_bad_sel_w
         $error("stream_demux_1ton: SEL_W must equal clog2(NUM_CH)");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

   state_t            state, state_nxt;
   logic [SEL_W-1:0]  lch, lch_nxt;
   logic              rdy_en;

   // Output register stage (_p1): one beat, one cycle after acceptance
   logic              vld_p1;
   logic [SEL_W-1:0]  ch_p1;
   logic [DATA_W-1:0] data_p1;
   logic              last_p1;

   logic              sel_ok, drain, accept, load, err_nxt;
   logic [SEL_W-1:0]  ld_ch;

`ifdef STREAM_DEMUX_PKT_CNT_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
`endif

   // Handshake, packet FSM next state and output-register load decision
   always_comb begin
      state_nxt   = state;
      lch_nxt     = lch;
      load        = 1'b0;
      ld_ch       = '0;
      err_nxt     = 1'b0;
      sel_ok      = int'(bus.s_sel) < NUM_CH;
      drain       = vld_p1 && bus.m_ready[ch_p1];
      bus.s_ready = 1'b0;
      // s_ready never looks at s_valid; it only depends on the state and the sink's ready
      if (rdy_en) begin
         bus.s_ready = (state == DROP) ? 1'b1 : (!vld_p1 || drain);
      end
      accept = bus.s_valid && bus.s_ready;
      case (state)
         IDLE: begin
            if (accept) begin
               if (sel_ok) begin
                  load    = 1'b1;
                  ld_ch   = bus.s_sel;
                  lch_nxt = bus.s_sel;
                  if (!bus.s_last) state_nxt = PKT;
               end else begin
                  err_nxt = 1'b1;
                  if (!bus.s_last) state_nxt = DROP;
               end
            end
         end
         PKT: begin
            if (accept) begin
               load  = 1'b1;
               ld_ch = lch;
               if (bus.s_last) state_nxt = IDLE;
            end
         end
         DROP: begin
            if (accept && bus.s_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Packet state, channel lock, error pulse and post-reset ready enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         lch     <= '0;
         rdy_en  <= 1'b0;
         err_sel <= 1'b0;
      end else begin
         state   <= state_nxt;
         lch     <= lch_nxt;
         rdy_en  <= 1'b1;
         err_sel <= err_nxt;
      end
   end

   // Output register: a load overrides a drain, so the path has no bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         ch_p1   <= '0;
         data_p1 <= '0;
         last_p1 <= 1'b0;
      end else if (load) begin
         vld_p1  <= 1'b1;
         ch_p1   <= ld_ch;
         data_p1 <= bus.s_data;
         last_p1 <= bus.s_last;
      end else if (drain) begin
         vld_p1  <= 1'b0;
      end
   end

   // One-hot channel valid decoded from the held channel
   always_comb begin
      bus.m_valid = '0;
      if (vld_p1) bus.m_valid[ch_p1] = 1'b1;
   end

   assign bus.m_data = data_p1;
   assign bus.m_last = last_p1;

`ifdef STREAM_DEMUX_PKT_CNT_EN
   // Count packets whose last beat retires into a sink
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_count <= 16'd0;
      end else if (drain && last_p1) begin
         pkt_count <= sat_inc16(pkt_count);
      end
   end
`endif

endmodule

// File: tb/tb_stream_demux_1ton.sv
// tb_stream_demux_1ton: drives a 16-channel and a 12-channel demux with identical
// ingress beats. A packet-level scoreboard, kept separately for each instance,
// predicts which beats get delivered, where they go, and when they appear.
module tb_stream_demux_1ton;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic err16, err12;
`ifdef STREAM_DEMUX_PKT_CNT_EN
   logic [15:0] cnt16, cnt12;
`endif

   always #5 clk = ~clk;

   stream_demux_if #(.DATA_W(8), .NUM_CH(16), .SEL_W(4)) bus16 ();
   stream_demux_if #(.DATA_W(8), .NUM_CH(12), .SEL_W(4)) bus12 ();

   stream_demux_1ton #(.DATA_W(8), .NUM_CH(16), .SEL_W(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .bus(bus16), .err_sel(err16)
`ifdef STREAM_DEMUX_PKT_CNT_EN
      , .pkt_count(cnt16)
`endif
   );

   stream_demux_1ton #(.DATA_W(8), .NUM_CH(12), .SEL_W(4)) dut12 (
      .clk(clk), .rst_n(rst_n), .bus(bus12), .err_sel(err12)
`ifdef STREAM_DEMUX_PKT_CNT_EN
      , .pkt_count(cnt12)
`endif
   );

   typedef struct packed {
      logic [7:0] ch;
      logic [7:0] data;
      logic       last;
   } beat_t;

   beat_t expq [2][$];
   int    nch [2] = '{16, 12};
   bit    in_pkt [2];
   bit    dropping [2];
   bit    err_exp [2];
   bit    acc [2];
   int    lch_m [2];
   int    pkts_m [2];
   bit    ready_en;
   int    n_checks = 0;
   int    n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] sel, input logic [7:0] data,
                        input logic last, input logic [15:0] rdy);
      bus16.s_valid = v;   bus12.s_valid = v;
      bus16.s_sel   = sel; bus12.s_sel   = sel;
      bus16.s_data  = data; bus12.s_data = data;
      bus16.s_last  = last; bus12.s_last = last;
      bus16.m_ready = rdy; bus12.m_ready = rdy[11:0];
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         expq[d].delete();
         in_pkt[d]   = 1'b0;
         dropping[d] = 1'b0;
         err_exp[d]  = 1'b0;
         acc[d]      = 1'b0;
         lch_m[d]    = 0;
         pkts_m[d]   = 0;
      end
      ready_en = 1'b0;
   endtask

   // Called at the falling edge: compare the outputs, then advance the model across the next rising edge
   task automatic step();
      logic [15:0] mv [2];
      logic [15:0] mr [2];
      logic [7:0]  md [2];
      logic        ml [2];
      logic        sr [2];
      logic        er [2];
`ifdef STREAM_DEMUX_PKT_CNT_EN
      logic [15:0] cn [2];
`endif
      logic        sv, sl;
      logic [3:0]  ss;
      logic [7:0]  sd;
      mv[0] = bus16.m_valid; mv[1] = {4'b0, bus12.m_valid};
      mr[0] = bus16.m_ready; mr[1] = {4'b0, bus12.m_ready};
      md[0] = bus16.m_data;  md[1] = bus12.m_data;
      ml[0] = bus16.m_last;  ml[1] = bus12.m_last;
      sr[0] = bus16.s_ready; sr[1] = bus12.s_ready;
      er[0] = err16;         er[1] = err12;
`ifdef STREAM_DEMUX_PKT_CNT_EN
      cn[0] = cnt16;         cn[1] = cnt12;
`endif
      sv = bus16.s_valid; sl = bus16.s_last; ss = bus16.s_sel; sd = bus16.s_data;
      for (int d = 0; d < 2; d++) begin
         beat_t f;
         beat_t b;
         logic  has, exp_sr, retire;
         f = '0;
         has = (expq[d].size() != 0);
         if (has) begin
            f = expq[d][0];
            check_eq($sformatf("d%0d_m_valid", d), 32'(mv[d]), 32'(1) << f.ch);
            check_eq($sformatf("d%0d_m_data", d), 32'(md[d]), 32'(f.data));
            check_eq($sformatf("d%0d_m_last", d), 32'(ml[d]), 32'(f.last));
         end else begin
            check_eq($sformatf("d%0d_m_valid_idle", d), 32'(mv[d]), 32'd0);
         end
         check_eq($sformatf("d%0d_err_sel", d), 32'(er[d]), 32'(err_exp[d]));
         exp_sr = ready_en && (dropping[d] || !has || mr[d][f.ch]);
         check_eq($sformatf("d%0d_s_ready", d), 32'(sr[d]), 32'(exp_sr));
`ifdef STREAM_DEMUX_PKT_CNT_EN
         check_eq($sformatf("d%0d_pkt_count", d), 32'(cn[d]), 32'(pkts_m[d]));
`endif
         acc[d]     = sv && sr[d];
         retire     = has && mr[d][f.ch];
         err_exp[d] = 1'b0;
         if (retire) begin
            if (f.last && pkts_m[d] < 65535) pkts_m[d]++;
            void'(expq[d].pop_front());
         end
         if (acc[d]) begin
            b.data = sd;
            b.last = sl;
            if (in_pkt[d]) begin
               b.ch = 8'(lch_m[d]);
               expq[d].push_back(b);
               if (sl) in_pkt[d] = 1'b0;
            end else if (dropping[d]) begin
               if (sl) dropping[d] = 1'b0;
            end else if (int'(ss) < nch[d]) begin
               lch_m[d] = int'(ss);
               b.ch = 8'(ss);
               expq[d].push_back(b);
               in_pkt[d] = !sl;
            end else begin
               err_exp[d]  = 1'b1;
               dropping[d] = !sl;
            end
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      step();
      @(posedge clk);
      if (rst_n) ready_en = 1'b1;
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 4'd0, 8'd0, 1'b0, 16'hFFFF);
      rst_n = 1'b0;
      #1;
      check_eq("rst_m_valid16", 32'(bus16.m_valid), 32'd0);
      check_eq("rst_m_valid12", 32'(bus12.m_valid), 32'd0);
      check_eq("rst_m_data16", 32'(bus16.m_data), 32'd0);
      check_eq("rst_m_last16", 32'(bus16.m_last), 32'd0);
      check_eq("rst_err16", 32'(err16), 32'd0);
      check_eq("rst_err12", 32'(err12), 32'd0);
      check_eq("rst_s_ready16", 32'(bus16.s_ready), 32'd0);
      check_eq("rst_s_ready12", 32'(bus12.s_ready), 32'd0);
`ifdef STREAM_DEMUX_PKT_CNT_EN
      check_eq("rst_pkt_count16", 32'(cnt16), 32'd0);
      check_eq("rst_pkt_count12", 32'(cnt12), 32'd0);
`endif
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int i, guard;
      logic [7:0] dat [4];
      drive(1'b0, 4'd0, 8'd0, 1'b0, 16'hFFFF);
      model_reset();
      #2;
      do_reset();
      cycle();
      cycle();

      // Single-beat packet to channel 5
      drive(1'b1, 4'd5, 8'hA5, 1'b1, 16'hFFFF);
      cycle();
      check_eq("tp1_m_valid", 32'(bus16.m_valid), 32'h0020);
      check_eq("tp1_m_data", 32'(bus16.m_data), 32'hA5);
      check_eq("tp1_m_last", 32'(bus16.m_last), 32'd1);
      check_eq("tp1_s_ready", 32'(bus16.s_ready), 32'd1);
      drive(1'b0, 4'd0, 8'd0, 1'b0, 16'hFFFF);
      cycle();

      // 4-beat packet locked to channel 3 although the select moves to 9
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, (k == 0) ? 4'd3 : 4'd9, 8'(8'h10 + k), k == 3, 16'hFFFF);
         cycle();
         check_eq("tp2_m_valid", 32'(bus16.m_valid), 32'h0008);
         check_eq("tp2_m_data", 32'(bus16.m_data), 32'(8'h10 + k));
         check_eq("tp2_m_last", 32'(bus16.m_last), (k == 3) ? 32'd1 : 32'd0);
      end
      drive(1'b0, 4'd0, 8'd0, 1'b0, 16'hFFFF);
      cycle();

      // Backpressure on channel 3 for three cycles in the middle of a packet
      dat = '{8'h21, 8'h22, 8'h23, 8'h24};
      i = 0;
      guard = 0;
      while (i < 4 && guard < 40) begin
         logic [15:0] rdy;
         rdy = (guard >= 2 && guard < 5) ? 16'hFFF7 : 16'hFFFF;
         drive(1'b1, 4'd3, dat[i], i == 3, rdy);
         cycle();
         if (guard >= 2 && guard < 5) begin
            check_eq("tp3_s_ready_held", 32'(bus16.s_ready), 32'd0);
            check_eq("tp3_m_data_held", 32'(bus16.m_data), 32'h22);
            check_eq("tp3_m_valid_held", 32'(bus16.m_valid), 32'h0008);
         end
         if (acc[0]) i++;
         guard++;
      end
      check_eq("tp3_all_beats_sent", 32'(i), 32'd4);
      drive(1'b0, 4'd0, 8'd0, 1'b0, 16'hFFFF);
      cycle();
      cycle();

      // Out-of-range select on the 12-channel instance, then a normal packet to channel 0
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 4'd13, 8'(8'h30 + k), k == 2, 16'hFFFF);
         cycle();
         check_eq("tp4_err12", 32'(err12), (k == 0) ? 32'd1 : 32'd0);
         check_eq("tp4_m_valid12", 32'(bus12.m_valid), 32'd0);
         check_eq("tp4_accepted12", 32'(acc[1]), 32'd1);
      end
      drive(1'b1, 4'd0, 8'h3C, 1'b1, 16'hFFFF);
      cycle();
      check_eq("tp4_ch0_m_valid12", 32'(bus12.m_valid), 32'h001);
      check_eq("tp4_ch0_m_data12", 32'(bus12.m_data), 32'h3C);
      check_eq("tp4_err12_quiet", 32'(err12), 32'd0);

      // Back-to-back packets: channel 2 (two beats), then channel 7 (one beat)
      drive(1'b1, 4'd2, 8'h41, 1'b0, 16'hFFFF);
      cycle();
      check_eq("tp5_m_valid_a", 32'(bus16.m_valid), 32'h0004);
      drive(1'b1, 4'd11, 8'h42, 1'b1, 16'hFFFF);
      cycle();
      check_eq("tp5_m_valid_b", 32'(bus16.m_valid), 32'h0004);
      drive(1'b1, 4'd7, 8'h43, 1'b1, 16'hFFFF);
      cycle();
      check_eq("tp5_m_valid_c", 32'(bus16.m_valid), 32'h0080);
      drive(1'b0, 4'd0, 8'd0, 1'b0, 16'hFFFF);
      cycle();

      // Reset while a beat is stuck in the output register mid-packet
      drive(1'b1, 4'd6, 8'h55, 1'b0, 16'h0000);
      cycle();
      cycle();
      do_reset();
      drive(1'b1, 4'd1, 8'h66, 1'b1, 16'hFFFF);
      cycle();
      cycle();
      check_eq("tp6_first_after_reset", 32'(bus16.m_valid), 32'h0002);
      drive(1'b0, 4'd0, 8'd0, 1'b0, 16'hFFFF);
      cycle();

      // Randomised traffic with random sink readiness and occasional resets
      for (int n = 0; n < 3000; n++) begin
         if (n == 1000 || n == 2000) do_reset();
         drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 8'($urandom),
               $urandom_range(0, 2) == 0,
               (n % 200 < 40) ? 16'hFFFF : 16'($urandom | $urandom));
         cycle();
      end
      drive(1'b0, 4'd0, 8'd0, 1'b0, 16'hFFFF);
      repeat (3) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/stream_demux_1ton.md
# stream_demux_1ton

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshaking and packet-level routing. The channel select is sampled on the first beat of each packet and held until the last beat. Beats are delivered through a single output register to one of NUM_CH sinks. Packets with an out-of-range select are dropped. It is the clocked successor to the team's combinational demux blocks and sits between a single ingress stream and per-channel consumers.

## Interface
- DATA_W, 8, payload width in bits (≥1)
- NUM_CH, 16, number of output channels (2..256)
- SEL_W, 4, select width; must equal ceil(log2(NUM_CH)), elaboration error otherwise
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- s_valid  input  1  ingress beat valid
- s_ready  output  1  ingress beat accepted when s_valid && s_ready
- s_data  input  DATA_W  ingress payload
- s_sel  input  SEL_W  destination channel; sampled only on first beat of a packet
- s_last  input  1  final beat of packet
- m_valid  output  NUM_CH  one-hot (or zero) per-channel valid
- m_ready  input  NUM_CH  per-channel ready
- m_data  output  DATA_W  shared payload bus, meaningful for the channel with m_valid set
- m_last  output  1  shared last flag
- err_sel  output  1  one-cycle pulse: packet dropped, select ≥ NUM_CH

## Operation
- Internal state: output register {ov, och, odata, olast}, FSM {IDLE, PKT, DROP}, locked channel lch.
- IDLE: the next accepted beat is the first beat of a packet.
  - s_sel < NUM_CH: lch ← s_sel; beat loaded into output register with och = s_sel; go to PKT unless s_last.
  - s_sel ≥ NUM_CH: beat discarded; err_sel pulses next cycle; go to DROP unless s_last (single-beat bad packet: pulse, stay IDLE).
- PKT: accepted beats load the output register with och = lch; s_sel ignored; the s_last beat returns the FSM to IDLE.
- DROP: s_ready = 1, beats consumed and discarded; the s_last beat returns to IDLE; no further err_sel pulses.
- Output drain: beat retires when ov && m_ready[och]. m_valid = ov ? (1 << och) : 0.
- s_ready (IDLE/PKT) = !ov || m_ready[och], combinational. Accept and drain in the same cycle replace the register contents with no bubble.
- Held beat: m_data, m_last and m_valid stay stable while ov && !m_ready[och]. m_ready of non-selected channels is ignored.
- Back-to-back packets to different channels: the new first beat is accepted in the cycle the previous last beat drains. och switches with no idle cycle.

## Timing
- Latency: accepted beat visible on m_* one cycle after acceptance.
- Throughput: one beat per cycle per stream while the selected sink holds m_ready high.
- Reset (async assert, sync-released use): ov = 0, m_valid = 0, m_data = 0, m_last = 0, err_sel = 0, FSM = IDLE, lch = 0, s_ready = 0 while rst_n low. s_ready = 1 from the first edge after release.
- Reset mid-packet: in-flight beat and packet lock are discarded. The next beat after release is treated as a first beat.
- Combinational path m_ready → s_ready exists; no path s_valid → s_ready.
- err_sel asserted exactly one cycle, the cycle after the offending beat is accepted.

## Configuration
- STREAM_DEMUX_PKT_CNT_EN defined:
  - Adds output pkt_count [15:0], the number of packets whose last beat drained (ov && olast && m_ready[och]).
  - Saturates at 16'hFFFF; reset value 0.
  - Dropped packets are not counted.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Reset then single-beat packet s_sel=5, s_data=8'hA5, s_last=1, m_ready=all 1 → m_valid=16'h0020, m_data=8'hA5, m_last=1 one cycle later; s_ready stays 1.
- 4-beat packet to ch 3, s_sel changes to 9 on beats 2–4 → all beats on ch 3 only, data order preserved; m_last on beat 4 only.
- Backpressure: m_ready[3]=0 for 3 cycles mid-packet → s_ready=0, m_data/m_valid held stable, no beat lost or duplicated; resumes at 1 beat/cycle.
- Out-of-range select with NUM_CH=12, s_sel=13, 3-beat packet → err_sel one pulse, m_valid remains 0, 3 beats consumed. A following packet to ch 0 delivers normally.
- Back-to-back packets ch 2 (2 beats) then ch 7 (1 beat), continuous valid → no idle cycle; m_valid goes 0x0004, 0x0004, 0x0080.
- rst_n pulsed low mid-packet with ov=1 → all outputs 0 immediately. With STREAM_DEMUX_PKT_CNT_EN, pkt_count=0 after reset and increments by 1 per completed packet thereafter.
